// File: rtl/uart_byte_transmitter.sv
// Single-byte 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// A rising edge on tx_start while idle launches one frame; tx_done pulses when
// the stop bit has been held for a full bit period.
module uart_byte_transmitter #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_state,
  output logic       rs232_tx
);

  localparam int unsigned BPS      = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W    = ($clog2(BPS) > 20) ? $clog2(BPS) : 20;
  localparam int unsigned IDX_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP = IDX_W'(9);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(8);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           state, state_d;
  logic             start_q;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] baud_cnt, cnt_d;
  logic [IDX_W-1:0] bit_idx, idx_d;
  logic             done_d, busy_d, tx_d;
  logic             start_evt;

  // A start is a 0->1 transition of tx_start relative to the previous cycle.
  assign start_evt = tx_start & ~start_q;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_done  <= 1'b0;
      tx_state <= 1'b0;
      rs232_tx <= 1'b1;
    end else begin
      state    <= state_d;
      start_q  <= tx_start;
      data_q   <= data_d;
      baud_cnt <= cnt_d;
      bit_idx  <= idx_d;
      tx_done  <= done_d;
      tx_state <= busy_d;
      rs232_tx <= tx_d;
    end
  end

  // Next-state logic: bit timing, bit sequencing and next output values.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    cnt_d   = baud_cnt;
    idx_d   = bit_idx;
    done_d  = 1'b0;
    busy_d  = tx_state;
    tx_d    = rs232_tx;

    case (state)
      S_IDLE: begin
        if (start_evt) begin
          state_d = S_SEND;
          data_d  = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end

      S_SEND: begin
        if (baud_cnt == CNT_MAX) begin
          cnt_d = '0;
          if (bit_idx == IDX_STOP) begin
            // Stop bit complete: frame done, line stays high.
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            // bit_idx is the slot just finished; drive the following one.
            idx_d = bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              tx_d = 1'b1;
            end else begin
              tx_d = data_q[bit_idx[2:0]];
            end
          end
        end else begin
          cnt_d = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter: a BPS=10 instance for frame shape,
// start filtering, reset behaviour, plus a default-parameter instance for timing.
module tb_uart_byte_transmitter;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tx_state;
  logic       rs232_tx;

  logic       def_tx_start;
  logic [7:0] def_tx_data;
  logic       def_tx_done;
  logic       def_tx_state;
  logic       def_rs232_tx;

  int n_vec;
  int n_bad;
  int done_cnt;
  int base;

  uart_byte_transmitter #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .tx_state(tx_state),
    .rs232_tx(rs232_tx)
  );

  uart_byte_transmitter u_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(def_tx_start),
    .tx_data (def_tx_data),
    .tx_done (def_tx_done),
    .tx_state(def_tx_state),
    .rs232_tx(def_rs232_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  initial done_cnt = 0;
  always @(negedge clk) if (tx_done) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise tx_start so the next edge is the acceptance edge T; return just after T.
  task automatic kick(input logic [7:0] d, input bit hold);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    if (!hold) tx_start = 1'b0;
  endtask

  // Check ncyc cycles of the frame from just after T; full frames also check done.
  task automatic frame_check(input logic [7:0] d, input bit disturb, input int ncyc);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      chk("line", 32'(rs232_tx), 32'(fr[k/10]));
      chk("busy", 32'(tx_state), 32'd1);
      chk("done_early", 32'(tx_done), 32'd0);
      if (disturb && (k == 35 || k == 60)) begin
        tx_start = 1'b1;
        tx_data  = 8'h55;
      end else if (disturb && (k == 36 || k == 61)) begin
        tx_start = 1'b0;
      end
      step();
    end
    if (ncyc == 100) begin
      chk("done_pulse", 32'(tx_done), 32'd1);
      chk("busy_end", 32'(tx_state), 32'd0);
      chk("line_end", 32'(rs232_tx), 32'd1);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    def_tx_start = 1'b0;
    def_tx_data  = 8'h00;

    // Reset values
    repeat (3) step();
    chk("rst_line", 32'(rs232_tx), 32'd1);
    chk("rst_busy", 32'(tx_state), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_def_line", 32'(def_rs232_tx), 32'd1);
    rst_n = 1'b1;
    step();

    // Single frame A5
    base = done_cnt;
    kick(8'hA5, 1'b0);
    frame_check(8'hA5, 1'b0, 100);
    step();
    chk("a5_done_cnt", 32'(done_cnt - base), 32'd1);

    // Back-to-back 00 then FF, start 2 clocks after each done
    base = done_cnt;
    chk("gap_line", 32'(rs232_tx), 32'd1);
    kick(8'h00, 1'b0);
    frame_check(8'h00, 1'b0, 100);
    step();
    chk("gap_line2", 32'(rs232_tx), 32'd1);
    kick(8'hFF, 1'b0);
    frame_check(8'hFF, 1'b0, 100);
    step();
    chk("b2b_done_cnt", 32'(done_cnt - base), 32'd2);

    // Held start: one frame only
    base = done_cnt;
    kick(8'h3C, 1'b1);
    frame_check(8'h3C, 1'b0, 100);
    for (int k = 0; k < 149; k++) begin
      step();
      chk("hold_busy", 32'(tx_state), 32'd0);
      chk("hold_line", 32'(rs232_tx), 32'd1);
    end
    tx_start = 1'b0;
    step();
    chk("hold_done_cnt", 32'(done_cnt - base), 32'd1);

    // Starts and data changes during a frame are ignored
    base = done_cnt;
    kick(8'hC3, 1'b0);
    frame_check(8'hC3, 1'b1, 100);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("dist_idle", 32'(tx_state), 32'd0);
    end
    chk("dist_done_cnt", 32'(done_cnt - base), 32'd1);

    // Reset mid-frame, then a full frame
    base = done_cnt;
    kick(8'h5A, 1'b0);
    frame_check(8'h5A, 1'b0, 45);
    rst_n = 1'b0;
    step();
    chk("mrst_line", 32'(rs232_tx), 32'd1);
    chk("mrst_busy", 32'(tx_state), 32'd0);
    chk("mrst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (110) step();
    chk("mrst_no_done", 32'(done_cnt - base), 32'd0);
    kick(8'h96, 1'b0);
    frame_check(8'h96, 1'b0, 100);
    step();
    chk("mrst_done_cnt", 32'(done_cnt - base), 32'd1);

    // tx_start already high at reset release starts a frame
    base = done_cnt;
    tx_data  = 8'hE7;
    tx_start = 1'b1;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    frame_check(8'hE7, 1'b0, 100);
    tx_start = 1'b0;
    step();
    chk("rel_done_cnt", 32'(done_cnt - base), 32'd1);

    // Default parameters (BPS=5208), byte 01
    def_tx_data  = 8'h01;
    def_tx_start = 1'b1;
    step();
    def_tx_start = 1'b0;
    chk("def_start_busy", 32'(def_tx_state), 32'd1);
    repeat (5207) step();
    chk("def_start_last", 32'(def_rs232_tx), 32'd0);
    step();
    chk("def_bit0_first", 32'(def_rs232_tx), 32'd1);
    repeat (5207) step();
    chk("def_bit0_last", 32'(def_rs232_tx), 32'd1);
    step();
    chk("def_bit1_first", 32'(def_rs232_tx), 32'd0);
    repeat (41663) step();
    chk("def_pre_done", 32'(def_tx_done), 32'd0);
    chk("def_pre_busy", 32'(def_tx_state), 32'd1);
    chk("def_stop", 32'(def_rs232_tx), 32'd1);
    step();
    chk("def_done", 32'(def_tx_done), 32'd1);
    chk("def_busy_end", 32'(def_tx_state), 32'd0);
    chk("def_line_end", 32'(def_rs232_tx), 32'd1);
    step();
    chk("def_done_once", 32'(def_tx_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_transmitter.md
Name: uart_byte_transmitter

Overview:
- Single-byte UART transmitter, 8N1 format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Sits under the Modbus RTU response sequencer.
- The sequencer presents a byte, pulses a start strobe, and waits for a done pulse before presenting the next byte.
- Output drives the RS-485 transceiver TX pin (line idles high).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bit/s.
- Derived constant BPS = CLK_FREQ/BAUD_RATE (integer division): clocks per bit. Must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- tx_start  input  1  start request; only its rising edge is significant.
- tx_data  input  8  byte to send; sampled when a start is accepted.
- tx_done  output  1  one-clock pulse when the stop bit has finished.
- tx_state  output  1  high while a frame is on the line (busy).
- rs232_tx  output  1  serial line output; idle high.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: on a rising clk edge with rst_n=0, all state clears.
  - Reset values: rs232_tx=1, tx_done=0, tx_state=0, edge-detect history=0, baud counter=0, bit index=0.
- Start detection:
  - tx_start is registered every cycle, busy or not.
  - A start event is tx_start=1 while the previous sampled value was 0.
  - A level held high triggers only once.
- Start acceptance:
  - A start event is accepted only when tx_state=0.
  - Events while busy are dropped, not queued.
- Acceptance edge T (the rising clk edge that sees the start event). At this edge:
  - tx_data is latched into a shift/hold register.
  - tx_state becomes 1.
  - rs232_tx becomes 0 (start bit).
  - The baud counter clears.
- Frame timing relative to T (each bit held exactly BPS clocks):
  - Start bit: outputs after edges T .. T+BPS-1.
  - Data bit i (i=0..7, LSB first): driven from edge T+(i+1)*BPS.
  - Stop bit (1): driven from edge T+9*BPS.
  - At edge T+10*BPS: tx_state=0 and tx_done=1 for exactly one clock; rs232_tx stays 1.
  - Total frame is 10*BPS clocks.
- Idle and re-start:
  - After done, the transmitter is idle.
  - A new start event at edge T+10*BPS+1 or later is accepted.
  - A start event coinciding with the tx_done cycle is also accepted, because tx_state is already 0.
- Data stability: tx_data changes after T have no effect on the frame in flight.
- Counters:
  - Baud counter counts 0..BPS-1 and wraps, advancing the bit index at the wrap.
  - Bit index counts 0..9.
  - Counter width must be sufficient for BPS-1 (at least 20 bits for the defaults).
- tx_done only follows a complete frame; it is never asserted otherwise.
- Reset mid-frame: at the reset edge the line returns to 1 and tx_state to 0; no tx_done is produced; the frame is abandoned.
- Reset release with tx_start already high: the history resets to 0, so a high tx_start on the first post-reset cycle counts as a rising edge and starts a frame.

Test Plan:
- Sim parameters CLK_FREQ=1000, BAUD_RATE=100 (BPS=10); after reset, pulse tx_start for one clock with tx_data=8'hA5.
  -> rs232_tx = 0 for 10 clocks, then 1,0,1,0,0,1,0,1 (10 clocks each), then 1 for 10 clocks.
  -> tx_state=1 for exactly 100 clocks.
  -> tx_done single-clock pulse at edge T+100.
- Same setup, tx_data=8'h00 then 8'hFF, back-to-back with the start pulse 2 clocks after each tx_done.
  -> both frames decode correctly; line high between frames.
  -> exactly two tx_done pulses.
- tx_start held high for 250 clocks with tx_data=8'h3C.
  -> exactly one frame, one tx_done; no retrigger after done while still high.
- Extra tx_start pulses and tx_data changes to 8'h55 at T+35 and T+60 during a frame of 8'hC3.
  -> frame still transmits 8'hC3; no extra frame; one tx_done.
- rst_n=0 for 1 clock at T+45 during a frame.
  -> next edge: rs232_tx=1, tx_state=0; no tx_done.
  -> a subsequent start sends a full correct frame.
- Default parameters (BPS=5208), byte 8'h01.
  -> bit 0 (1) occupies clocks T+5208..T+10415.
  -> tx_done at T+52080.
